// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store port and the memory
// port that meet at mem_arbiter.
//   slave  - arbiter side: takes requests and memory q, drives completions,
//            read data and the memory address/write controls.
//   master - the opposite view, for requesters and the memory model.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  // load/store port
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic              ls_unsigned;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic [31:0]       ls_rdata;
  logic              ls_done;
  logic              ls_fault;
  // memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_unsigned, ls_addr,
           ls_wdata, mem_rdata,
    output if_data, if_done, ls_rdata, ls_done, ls_fault, mem_addr, mem_we,
           mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_unsigned, ls_addr,
           ls_wdata, mem_rdata,
    input  if_data, if_done, ls_rdata, ls_done, ls_fault, mem_addr, mem_we,
           mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port arbiter/sequencer between instruction fetch and
// load/store in front of a 512x32 memory with two-cycle registered reads.
// Sub-word stores are read-modify-write; loads are sign/zero extended.
// Ports:
//   clk, reset (sync, active high), clk_enable (global advance qualifier)
//   bus (mem_arbiter_if.slave): fetch, load/store and memory ports
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise load/store has fixed priority over fetch.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_enable,
  mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              gnt_ls_q, gnt_ls_d;     // 1: current access belongs to LS
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;         // word captured in RD2 for RMW
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;
`ifdef MEM_ARB_RR_EN
  logic              last_ls_q, last_ls_d;   // 1: LS was granted last
`endif

  logic              pick_ls, pick_if, ls_bad;
  logic [ADDR_W-1:0] win_addr;
  logic [4:0]        sh;
  logic [31:0]       ld_sh, ld_ext, lane_mask, wr_word;

  // arbitration and alignment check, evaluated in IDLE
  always_comb begin
`ifdef MEM_ARB_RR_EN
    pick_ls = bus.ls_req && (!bus.if_req || !last_ls_q);
`else
    pick_ls = bus.ls_req;
`endif
    pick_if  = bus.if_req && !pick_ls;
    win_addr = (pick_ls ? bus.ls_addr : bus.if_addr) & ~ADDR_W'(3);
    ls_bad   = (bus.ls_size == 2'b11) ||
               (bus.ls_size == 2'b01 && bus.ls_addr[0]) ||
               (bus.ls_size == 2'b10 && bus.ls_addr[1:0] != 2'b00);
  end

  // lane extraction for loads and lane insertion for sub-word stores;
  // the requester holds its fields, so the live ls_* inputs are used
  always_comb begin
    sh = (bus.ls_size == 2'b00) ? {bus.ls_addr[1:0], 3'b000}
                                : {bus.ls_addr[1], 4'b0000};
    ld_sh = bus.mem_rdata >> sh;
    case (bus.ls_size)
      2'b00:   ld_ext = {{24{~bus.ls_unsigned & ld_sh[7]}}, ld_sh[7:0]};
      2'b01:   ld_ext = {{16{~bus.ls_unsigned & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = bus.mem_rdata;
    endcase
    lane_mask = ((bus.ls_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    wr_word   = (bus.ls_size == 2'b10) ? bus.ls_wdata
              : ((word_q & ~lane_mask) | ((bus.ls_wdata << sh) & lane_mask));
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_ls_q   <= 1'b0;
      fault_q    <= 1'b0;
      addr_q     <= '0;
      word_q     <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_ls_q  <= 1'b1;                    // IF wins the first tie
`endif
    end else if (clk_enable) begin
      state_q    <= state_d;
      gnt_ls_q   <= gnt_ls_d;
      fault_q    <= fault_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_ls_q  <= last_ls_d;
`endif
    end
  end

  // next state
  always_comb begin
    state_d    = state_q;
    gnt_ls_d   = gnt_ls_q;
    fault_d    = fault_q;
    addr_d     = addr_q;
    word_d     = word_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_ls_d  = last_ls_q;
`endif
    case (state_q)
      S_IDLE: if (pick_ls || pick_if) begin
        gnt_ls_d = pick_ls;
        addr_d   = win_addr;
        fault_d  = pick_ls && ls_bad;
`ifdef MEM_ARB_RR_EN
        last_ls_d = pick_ls;
`endif
        if (pick_ls && ls_bad)                                 state_d = S_DONE;
        else if (pick_ls && bus.ls_we && bus.ls_size == 2'b10) state_d = S_WR;
        else                                                   state_d = S_RD1;
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        word_d = bus.mem_rdata;
        if (gnt_ls_q && bus.ls_we) state_d = S_WR;
        else begin
          state_d = S_DONE;
          // load results are registered on entry to DONE so they are
          // valid alongside the done pulse
          if (gnt_ls_q) ls_rdata_d = ld_ext;
          else          if_data_d  = bus.mem_rdata;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs; the write strobe and completions are masked during reset so an
  // aborted access neither writes nor completes
  always_comb begin
    bus.mem_addr  = addr_q;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.if_done   = 1'b0;
    bus.ls_done   = 1'b0;
    bus.ls_fault  = 1'b0;
    case (state_q)
      S_IDLE: bus.mem_addr = win_addr;
      S_WR: begin
        bus.mem_we    = clk_enable && !reset;
        bus.mem_wdata = wr_word;
      end
      S_DONE: begin
        bus.ls_done  = gnt_ls_q && !reset;
        bus.ls_fault = gnt_ls_q && fault_q && !reset;
        bus.if_done  = !gnt_ls_q && !reset;
      end
      default: ;
    endcase
  end

  assign bus.if_data  = if_data_q;
  assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter. Drivers compute
// expected results from a byte-level shadow memory and push them into queues;
// monitors pop and compare on every done pulse, including completion latency.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_enable = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int exp_writes = 0;

  function automatic logic [31:0] init_word(int i);
    if (i == 8) return 32'h1122_3344;        // word @0x20
    return (32'h9E37_79B1 * i[31:0]) ^ 32'h5A5A_0000;
  endfunction

  // memory: address register then output register -> q valid two cycles on
  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];
  logic [8:0]  ra;
  logic [31:0] q;
  assign bus.mem_rdata = q;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[10:2]] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    ra <= bus.mem_addr[10:2];
    q  <= mem[ra];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          issue;
  } exp_t;
  exp_t ls_q[$];
  exp_t if_q[$];
  exp_t ls_e, if_e;

  // monitors
  always @(negedge clk) begin
    if (bus.ls_done) begin
      if (ls_q.size() == 0) check("ls_unexpected_done", 32'(ls_q.size()), 1);
      else begin
        ls_e = ls_q.pop_front();
        check("ls_fault", 32'(bus.ls_fault), 32'(ls_e.fault));
        check("ls_latency", 32'(cyc - ls_e.issue), 32'(ls_e.lat));
        if (ls_e.chk_data) check("ls_rdata", bus.ls_rdata, ls_e.data);
      end
    end
    if (bus.if_done) begin
      if (if_q.size() == 0) check("if_unexpected_done", 32'(if_q.size()), 1);
      else begin
        if_e = if_q.pop_front();
        check("if_latency", 32'(cyc - if_e.issue), 32'(if_e.lat));
        check("if_data", bus.if_data, if_e.data);
      end
    end
  end

  // reference model: byte-addressed view of the shadow memory
  task automatic model_ls(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output exp_t e);
    logic [7:0]  b [4];
    logic [31:0] w;
    int n, k, idx;
    idx = int'(addr[10:2]);
    e.issue = cyc; e.chk_data = 1'b0; e.data = '0; e.lat = 0;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.fault = (size == 2'd3) || (addr % n != 0);
    if (e.fault) begin e.lat = 1; return; end
    for (int j = 0; j < 4; j++) b[j] = ref_mem[idx][8*j +: 8];
    k = int'(addr % 4);
    if (we) begin
      for (int j = 0; j < n; j++) b[k+j] = wdata[8*j +: 8];
      ref_mem[idx] = {b[3], b[2], b[1], b[0]};
      exp_writes++;
      e.lat = (n == 4) ? 2 : 4;
    end else begin
      w = '0;
      for (int j = 0; j < n; j++) w[8*j +: 8] = b[k+j];
      if (!uns && w[8*n-1]) w = w | (32'hFFFF_FFFF << (8*n));
      e.chk_data = 1'b1; e.data = w; e.lat = 3;
    end
  endtask

  task automatic wait_done(input logic is_ls);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = is_ls ? bus.ls_done : bus.if_done;
    end
    check(is_ls ? "ls_done_seen" : "if_done_seen", 32'(seen), 1);
  endtask

  // called at a negedge with the arbiter idle
  task automatic ls_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int stall, input int extra);
    exp_t e;
    model_ls(we, size, uns, addr, wdata, e);
    e.lat += stall + extra;
    ls_q.push_back(e);
    bus.ls_we = we; bus.ls_size = size; bus.ls_unsigned = uns;
    bus.ls_addr = addr; bus.ls_wdata = wdata; bus.ls_req = 1'b1;
    if (stall > 0) begin
      @(negedge clk);
      clk_enable = 1'b0;
      repeat (stall) @(negedge clk);
      clk_enable = 1'b1;
    end
    wait_done(1'b1);
    bus.ls_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic if_op(input logic [31:0] addr, input int extra);
    exp_t e;
    e.issue = cyc; e.chk_data = 1'b1; e.fault = 1'b0;
    e.data = ref_mem[addr[10:2]]; e.lat = 3 + extra;
    if_q.push_back(e);
    bus.if_addr = addr; bus.if_req = 1'b1;
    wait_done(1'b0);
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  // byte store aborted by reset while its write is pending
  task automatic abort_store(input logic [31:0] addr, input logic [31:0] wdata);
    bus.ls_we = 1'b1; bus.ls_size = 2'd0; bus.ls_unsigned = 1'b0;
    bus.ls_addr = addr; bus.ls_wdata = wdata; bus.ls_req = 1'b1;
    repeat (3) @(negedge clk);
    check("we_in_wr", 32'(bus.mem_we), 1);
    reset = 1'b1; bus.ls_req = 1'b0;
    #1 check("we_during_reset", 32'(bus.mem_we), 0);
    @(negedge clk);
    reset = 1'b0;
    check("no_done_after_reset", 32'(bus.ls_done), 0);
    check("ls_rdata_after_reset", bus.ls_rdata, 0);
    @(negedge clk);
  endtask

  initial begin
    int w0, r, nbad;
    logic [31:0] a;
    logic [1:0]  sz;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'd0;
    bus.ls_unsigned = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    mem_init = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("rst_done", {29'd0, bus.if_done, bus.ls_done, bus.ls_fault}, 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_if_data", bus.if_data, 0);
    check("rst_ls_rdata", bus.ls_rdata, 0);

    w0 = wr_cnt;
    ls_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 0);
    check("word_store_writes", 32'(wr_cnt - w0), 1);
    ls_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 0);
    ls_op(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AB, 0, 0);
    check("byte_rmw_word", mem[8], 32'h11AB_3344);
    ls_op(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 0, 0);
    ls_op(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 0, 0);
    ls_op(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_8001, 0, 0);
    ls_op(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0, 0);
    w0 = wr_cnt;
    ls_op(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0, 0);
    ls_op(1'b1, 2'd3, 1'b0, 32'h14, 32'h5555_5555, 0, 0);
    check("fault_no_write", 32'(wr_cnt - w0), 0);
    ls_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, 0);
    abort_store(32'h25, 32'h0000_0077);
    ls_op(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 0, 0);

    for (int k = 0; k < 2; k++) begin
`ifdef MEM_ARB_RR_EN
      fork
        ls_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 4);
        if_op(32'h20, 0);
      join
`else
      fork
        ls_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 0);
        if_op(32'h20, 4);
      join
`endif
    end

    for (int i = 0; i < 80; i++) begin
      r  = int'($urandom_range(0, 9));
      a  = 32'($urandom_range(0, 2047));
      sz = 2'($urandom_range(0, 3));
      if (r < 2) if_op(a & ~32'h3, 0);
      else begin
        if (r < 6 && sz == 2'd1) a = a & ~32'h1;
        if (r < 6 && sz == 2'd2) a = a & ~32'h3;
        ls_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              $urandom, 0, 0);
      end
    end

    repeat (3) @(negedge clk);
    nbad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check("mem_image_bad_words", 32'(nbad), 0);
    check("write_count", 32'(wr_cnt), 32'(exp_writes));
    check("ls_queue_left", 32'(ls_q.size()), 0);
    check("if_queue_left", 32'(if_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter and sequencer between the instruction-fetch unit and the load/store unit, sitting directly in front of the 512×32 word memory. It grants one requester at a time, absorbs the memory's two-cycle registered read latency, and performs byte and halfword loads and stores. The memory has no byte enables, so sub-word stores are done as read-modify-write, and loads are sign- or zero-extended.

## Interface
- Parameters:
- `ADDR_W`, default 32: byte-address width on all ports.
- Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `clk_enable` in 1: global advance qualifier; when low, all state and outputs hold and `mem_we` is forced to 0.
- `if_req` in 1: fetch request, level, held until `if_done`.
- `if_addr` in ADDR_W: fetch byte address; word access only.
- `if_data` out 32: fetched word; valid while `if_done` is high and held until the next fetch completes.
- `if_done` out 1: one-cycle completion pulse.
- `ls_req` in 1: load/store request, level, held until `ls_done`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is illegal and faults.
- `ls_unsigned` in 1: zero-extend loads instead of sign-extend.
- `ls_addr` in ADDR_W: byte address.
- `ls_wdata` in 32: store data, right-aligned.
- `ls_rdata` out 32: extended load data; valid while `ls_done` is high and held afterwards.
- `ls_done` out 1: one-cycle completion pulse.
- `ls_fault` out 1: high with `ls_done` on a misaligned or illegal access.
- `mem_addr` out ADDR_W: to memory address port; the memory uses bits [10:2].
- `mem_we` out 1: memory write enable.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory q.

## Operation
- States: IDLE, RD1, RD2, WR, DONE.
- IDLE:
  - If `ls_req` is high, LS wins; fetch waits. If only `if_req` is high, IF wins.
  - `mem_addr` is driven combinationally from the winner's address with bits [1:0] zeroed, then latched into `addr_q`. In every other state `mem_addr` = `addr_q`.
- Misaligned access: half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Goes IDLE→DONE with `ls_fault`=1. No memory read or write is performed.
- Full-word store: IDLE→WR.
  - In WR, `mem_we`=1 and `mem_wdata`=`ls_wdata`. Then →DONE.
- Load, fetch, or sub-word store: IDLE→RD1→RD2.
  - In RD2, `mem_rdata` is valid and is captured.
  - Load or fetch: RD2→DONE.
  - Sub-word store: RD2→WR. In WR, `mem_wdata` is the captured word with the target lane replaced.
- Lane rules (little-endian):
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane = addr[1] occupies bits [16·addr[1]+15 : 16·addr[1]].
  - Loads shift the selected lane to bit 0, then sign- or zero-extend to 32 bits.
- DONE: pulses the winner's `*_done` (and `ls_fault` if applicable), updates `ls_rdata`/`if_data`, then →IDLE.
- A requester must not change its address or control fields between `req` and `done`.
- Outputs after reset: state IDLE; `if_done`, `ls_done`, `ls_fault`, `mem_we` = 0; `if_data`, `ls_rdata`, `mem_wdata`, `addr_q` = 0.

## Timing
- Latency is counted in enabled cycles from the IDLE cycle that accepts the request (c0).
- Word load, fetch: done in c3.
- Word store: done in c2; the write happens in c1.
- Sub-word store: read c0–c2, write c3, done in c4.
- Fault: done in c1.
- Back-to-back: a held request is re-arbitrated in the cycle after DONE. Minimum spacing between starts is 4 cycles for reads.
- `clk_enable` low: FSM freezes. `mem_addr` is stable, so memory q stays valid, and an RD2 capture resumes correctly. A pending write is deferred, never duplicated.
- Reset mid-operation:
  - `mem_we` is 0 during the reset cycle, even if the state is WR.
  - No `done` pulse is issued for the aborted access.
  - The FSM is in IDLE on the next cycle.
- Simultaneous `if_req` and `ls_req`: exactly one is granted. The loser sees no `done` and stays pending.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_grant` register prefers the requester not granted last when both request. Reset value: last = LS, so IF wins the first tie.
- Not defined: fixed LS-over-IF priority. A continuously requesting LS unit may starve fetch.

## Test plan
- Word store then load: store 0xDEADBEEF @0x10, then load word @0x10. `mem_we` pulses once; `ls_rdata`=0xDEADBEEF with `ls_done` in c3.
- Byte RMW: memory @0x20 = 0x11223344. Store byte 0xAB @0x22 → memory = 0x11AB3344. Load byte @0x22 signed → 0xFFFFFFAB; unsigned → 0x000000AB.
- Half load @0x22 of 0x8001xxxx → 0xFFFF8001.
- Misaligned word load @0x13 → `ls_fault`=1 with `ls_done` in c1; `mem_we` never asserts; memory unchanged.
- Contention: `if_req` and `ls_req` both held.
  - Without the macro: LS granted first, IF `done` 4 cycles later.
  - With `MEM_ARB_RR_EN`: grants alternate IF, LS, IF, …
- `clk_enable` low for 3 cycles during RD1, and `reset` asserted during WR of a byte store: correct data after resume; no write occurs and no `done` is issued after reset.
